hazard_ctrl: RTL and testbench

Central stall/flush scheduler for the 5-stage RV32I pipeline. It drives the enables and flushes of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves three hazard classes: load-use between ID and EX, control redirects resolved in EX, and variable-latency imem/dmem responses. It also tracks one outstanding imem request so that a stale fetch returning after a redirect is discarded.

---
 rtl/hazard_ctrl_pkg.sv | 44 ++++
 rtl/hazard_ctrl_if.sv | 42 ++++
 rtl/hazard_ctrl_sat_counter.sv | 25 ++
 rtl/hazard_ctrl.sv | 148 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard scheduler.
// The control bundle groups every stage enable/flush so whole-pipeline patterns can be named.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        DMEM_WAIT  = 2'd1,
        IMEM_DRAIN = 2'd2
    } hazard_state_t;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic imem_discard;
    } hazard_ctl_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    localparam hazard_ctl_t CTL_RESET    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam hazard_ctl_t CTL_RUN      = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam hazard_ctl_t CTL_FREEZE   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam hazard_ctl_t CTL_REDIRECT = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam hazard_ctl_t CTL_LOAD_USE = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam hazard_ctl_t CTL_DRAIN    = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    // A load in EX feeding a source of the instruction in ID; x0 never creates a dependency.
    function automatic logic load_use(
        input logic       ex_valid,
        input logic       ex_mem_read,
        input logic [4:0] ex_rd,
        input logic       id_valid,
        input logic [4:0] id_rs1,
        input logic [4:0] id_rs2
    );
        load_use = ex_valid & ex_mem_read & (ex_rd != REG_X0) & id_valid &
                   ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side hazard signals and the stage controls returned to the pipeline.
// master = pipeline datapath, slave = hazard controller.
interface hazard_ctrl_if #(parameter int CNT_W = 32);

    logic             id_valid;
    logic [4:0]       id_rs1_s;
    logic [4:0]       id_rs2_s;
    logic             ex_valid;
    logic             ex_mem_read;
    logic [4:0]       ex_rd_s;
    logic             ex_redirect;
    logic             imem_req;
    logic             imem_resp;
    logic             dmem_req;
    logic             dmem_resp;

    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             imem_discard;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_rs1_s, id_rs2_s, ex_valid, ex_mem_read, ex_rd_s,
               ex_redirect, imem_req, imem_resp, dmem_req, dmem_resp,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, imem_discard, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1_s, id_rs2_s, ex_valid, ex_mem_read, ex_rd_s,
               ex_redirect, imem_req, imem_resp, dmem_req, dmem_resp,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, imem_discard, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard performance statistics.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    // Count register; async active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + ONE;
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage RV32I pipeline: load-use, EX redirects,
// variable-latency imem/dmem, and discard of a stale fetch outstanding across a redirect.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hif
);

    hazard_state_t state_r;
    hazard_state_t state_s;
    logic          imem_pending_r;

    logic          dstall_s;
    logic          lu_s;
    hazard_ctl_t   run_ctl_s;
    logic          run_drain_s;
    logic          run_flush_s;
    logic          run_rules_s;
    hazard_ctl_t   ctl_s;
    hazard_ctl_t   out_s;
    logic          flush_inc_s;
    logic          stall_inc_s;

    assign dstall_s = hif.dmem_req & ~hif.dmem_resp;
    assign lu_s     = load_use(hif.ex_valid, hif.ex_mem_read, hif.ex_rd_s,
                               hif.id_valid, hif.id_rs1_s, hif.id_rs2_s);

    // Controls the RUN rules would produce, ignoring any dmem stall.
    always_comb begin
        run_ctl_s   = CTL_RUN;
        run_drain_s = 1'b0;
        run_flush_s = 1'b0;
        if (hif.ex_redirect) begin
            run_ctl_s   = CTL_REDIRECT;
            run_flush_s = 1'b1;
            if (hif.imem_resp) begin
                run_ctl_s.imem_discard = 1'b1;
            end else begin
                run_drain_s = imem_pending_r;
            end
        end else if (lu_s) begin
            run_ctl_s = CTL_LOAD_USE;
        end else begin
            run_ctl_s = CTL_RUN;
        end
    end

    // Next-state and control selection per state.
    always_comb begin
        state_s     = state_r;
        ctl_s       = CTL_RUN;
        run_rules_s = 1'b0;
        case (state_r)
            RUN: begin
                if (dstall_s) begin
                    ctl_s   = CTL_FREEZE;
                    state_s = DMEM_WAIT;
                end else begin
                    run_rules_s = 1'b1;
                end
            end
            DMEM_WAIT: begin
                if (hif.dmem_resp) begin
                    run_rules_s = 1'b1;
                end else begin
                    ctl_s = CTL_FREEZE;
                end
            end
            IMEM_DRAIN: begin
                ctl_s = CTL_DRAIN;
                if (dstall_s) begin
                    ctl_s.id_ex_en  = 1'b0;
                    ctl_s.ex_mem_en = 1'b0;
                    ctl_s.mem_wb_en = 1'b0;
                end else begin
                    ctl_s.id_ex_en  = 1'b1;
                end
                // The stale fetch arrives: drop it and leave, honouring any dmem stall.
                if (hif.imem_resp) begin
                    ctl_s.imem_discard = 1'b1;
                    state_s = dstall_s ? DMEM_WAIT : RUN;
                end else begin
                    state_s = IMEM_DRAIN;
                end
            end
            default: begin
                ctl_s   = CTL_FREEZE;
                state_s = RUN;
            end
        endcase
        if (run_rules_s) begin
            ctl_s   = run_ctl_s;
            state_s = run_drain_s ? IMEM_DRAIN : RUN;
        end else begin
            ctl_s.imem_discard = ctl_s.imem_discard;
        end
    end

    assign out_s       = rst ? ctl_s : CTL_RESET;
    assign flush_inc_s = run_rules_s & run_flush_s;
    assign stall_inc_s = ~out_s.pc_en;

    assign hif.pc_en        = out_s.pc_en;
    assign hif.if_id_en     = out_s.if_id_en;
    assign hif.id_ex_en     = out_s.id_ex_en;
    assign hif.ex_mem_en    = out_s.ex_mem_en;
    assign hif.mem_wb_en    = out_s.mem_wb_en;
    assign hif.if_id_flush  = out_s.if_id_flush;
    assign hif.id_ex_flush  = out_s.id_ex_flush;
    assign hif.imem_discard = out_s.imem_discard;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= RUN;
        end else begin
            state_r <= state_s;
        end
    end

    // Tracks one outstanding imem request; a same-cycle new request keeps it set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            imem_pending_r <= 1'b0;
        end else begin
            imem_pending_r <= hif.imem_req | (imem_pending_r & ~hif.imem_resp);
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc_s),
        .cnt (hif.stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_inc_s),
        .cnt (hif.flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; a second CNT_W=2 instance shares
// the same stimulus to exercise counter saturation.
module tb_hazard_ctrl;

    // Control vector order: pc,if_id,id_ex,ex_mem,mem_wb enables, if_id/id_ex flush, discard.
    localparam logic [7:0] V_RST   = 8'b00000_110;
    localparam logic [7:0] V_RUN   = 8'b11111_000;
    localparam logic [7:0] V_FRZ   = 8'b00000_000;
    localparam logic [7:0] V_RDR   = 8'b11111_110;
    localparam logic [7:0] V_RDRD  = 8'b11111_111;
    localparam logic [7:0] V_LU    = 8'b00111_010;
    localparam logic [7:0] V_DRN   = 8'b00111_100;
    localparam logic [7:0] V_DRND  = 8'b00111_101;
    localparam logic [7:0] V_DRNS  = 8'b00000_100;
    localparam logic [7:0] V_DRNSD = 8'b00000_101;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    hazard_ctrl_if #(.CNT_W(32)) hif ();
    hazard_ctrl_if #(.CNT_W(2))  hif_s ();

    hazard_ctrl #(.CNT_W(32)) dut   (.clk(clk), .rst(rst), .hif(hif));
    hazard_ctrl #(.CNT_W(2))  dut_s (.clk(clk), .rst(rst), .hif(hif_s));

    assign hif_s.id_valid    = hif.id_valid;
    assign hif_s.id_rs1_s    = hif.id_rs1_s;
    assign hif_s.id_rs2_s    = hif.id_rs2_s;
    assign hif_s.ex_valid    = hif.ex_valid;
    assign hif_s.ex_mem_read = hif.ex_mem_read;
    assign hif_s.ex_rd_s     = hif.ex_rd_s;
    assign hif_s.ex_redirect = hif.ex_redirect;
    assign hif_s.imem_req    = hif.imem_req;
    assign hif_s.imem_resp   = hif.imem_resp;
    assign hif_s.dmem_req    = hif.dmem_req;
    assign hif_s.dmem_resp   = hif.dmem_resp;

    logic [7:0] ov;
    assign ov = {hif.pc_en, hif.if_id_en, hif.id_ex_en, hif.ex_mem_en, hif.mem_wb_en,
                 hif.if_id_flush, hif.id_ex_flush, hif.imem_discard};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        hif.id_valid    = 1'b0;
        hif.id_rs1_s    = 5'd0;
        hif.id_rs2_s    = 5'd0;
        hif.ex_valid    = 1'b0;
        hif.ex_mem_read = 1'b0;
        hif.ex_rd_s     = 5'd0;
        hif.ex_redirect = 1'b0;
        hif.imem_req    = 1'b0;
        hif.imem_resp   = 1'b0;
        hif.dmem_req    = 1'b0;
        hif.dmem_resp   = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        hif.ex_valid    = 1'b1;
        hif.ex_mem_read = 1'b1;
        hif.ex_rd_s     = rd;
        hif.id_valid    = 1'b1;
        hif.id_rs1_s    = rs1;
        hif.id_rs2_s    = rs2;
    endtask

    // Step to just after the next rising edge so new inputs land mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        idle();
        #1;
        chk("reset_ctl", {24'd0, ov}, {24'd0, V_RST});
        chk("reset_stall_cnt", hif.stall_cnt, 32'd0);
        chk("reset_flush_cnt", hif.flush_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        idle();
        #2;
        chk("por_ctl", {24'd0, ov}, {24'd0, V_RST});
        do_reset();

        // Load-use: lw x5 in EX, add x6,x5,x1 in ID.
        tick(); set_lu(5'd5, 5'd5, 5'd1); settle();
        chk("lu_stall", {24'd0, ov}, {24'd0, V_LU});
        tick(); hif.ex_valid = 1'b0; hif.ex_mem_read = 1'b0; settle();
        chk("lu_release", {24'd0, ov}, {24'd0, V_RUN});
        chk("lu_stall_cnt", hif.stall_cnt, 32'd1);
        // Load to x0 with unused rs1: no hazard.
        tick(); set_lu(5'd0, 5'd0, 5'd0); settle();
        chk("lu_x0", {24'd0, ov}, {24'd0, V_RUN});
        // Match on rs2 only.
        tick(); set_lu(5'd7, 5'd3, 5'd7); settle();
        chk("lu_rs2", {24'd0, ov}, {24'd0, V_LU});
        tick(); idle(); settle();
        chk("lu_stall_cnt2", hif.stall_cnt, 32'd2);

        // dmem: zero-latency response, then a 3-cycle wait.
        do_reset();
        tick(); hif.dmem_req = 1'b1; hif.dmem_resp = 1'b1; settle();
        chk("dmem_zero_lat", {24'd0, ov}, {24'd0, V_RUN});
        tick(); hif.dmem_resp = 1'b0; settle();
        chk("dmem_w1", {24'd0, ov}, {24'd0, V_FRZ});
        tick(); settle();
        chk("dmem_w2", {24'd0, ov}, {24'd0, V_FRZ});
        tick(); settle();
        chk("dmem_w3", {24'd0, ov}, {24'd0, V_FRZ});
        tick(); hif.dmem_resp = 1'b1; settle();
        chk("dmem_resume", {24'd0, ov}, {24'd0, V_RUN});
        tick(); idle(); settle();
        chk("dmem_stall_cnt", hif.stall_cnt, 32'd3);

        // Redirect with a fetch outstanding; stale response two cycles later.
        do_reset();
        tick(); hif.imem_req = 1'b1; settle();
        chk("fetch_issue", {24'd0, ov}, {24'd0, V_RUN});
        tick(); hif.imem_req = 1'b0; hif.ex_redirect = 1'b1; settle();
        chk("redir_flush", {24'd0, ov}, {24'd0, V_RDR});
        tick(); hif.ex_redirect = 1'b0; settle();
        chk("drain_1", {24'd0, ov}, {24'd0, V_DRN});
        tick(); hif.imem_resp = 1'b1; settle();
        chk("drain_discard", {24'd0, ov}, {24'd0, V_DRND});
        tick(); idle(); settle();
        chk("drain_exit", {24'd0, ov}, {24'd0, V_RUN});
        chk("drain_flush_cnt", hif.flush_cnt, 32'd1);
        chk("drain_stall_cnt", hif.stall_cnt, 32'd2);
        // Redirect coinciding with the imem response: discard, no drain.
        tick(); hif.ex_redirect = 1'b1; hif.imem_resp = 1'b1; settle();
        chk("redir_resp", {24'd0, ov}, {24'd0, V_RDRD});
        tick(); idle(); settle();
        chk("redir_resp_next", {24'd0, ov}, {24'd0, V_RUN});
        chk("redir_flush_cnt2", hif.flush_cnt, 32'd2);

        // dmem stall arriving while draining, still pending at exit.
        do_reset();
        tick(); hif.imem_req = 1'b1; settle();
        tick(); hif.imem_req = 1'b0; hif.ex_redirect = 1'b1; settle();
        chk("redir2_flush", {24'd0, ov}, {24'd0, V_RDR});
        tick(); hif.ex_redirect = 1'b0; hif.dmem_req = 1'b1; settle();
        chk("drain_dstall", {24'd0, ov}, {24'd0, V_DRNS});
        tick(); hif.imem_resp = 1'b1; settle();
        chk("drain_dstall_disc", {24'd0, ov}, {24'd0, V_DRNSD});
        tick(); hif.imem_resp = 1'b0; settle();
        chk("drain_to_dwait", {24'd0, ov}, {24'd0, V_FRZ});
        tick(); hif.dmem_resp = 1'b1; settle();
        chk("dwait_resume", {24'd0, ov}, {24'd0, V_RUN});
        tick(); idle(); settle();
        chk("drain_dstall_cnt", hif.stall_cnt, 32'd3);

        // Redirect and load-use together: redirect wins.
        do_reset();
        tick(); set_lu(5'd5, 5'd5, 5'd1); hif.ex_redirect = 1'b1; settle();
        chk("redir_over_lu", {24'd0, ov}, {24'd0, V_RDR});
        tick(); idle(); settle();
        chk("redir_lu_stall_cnt", hif.stall_cnt, 32'd0);
        chk("redir_lu_flush_cnt", hif.flush_cnt, 32'd1);

        // Mid-operation reset while waiting on dmem.
        tick(); hif.dmem_req = 1'b1; settle();
        chk("pre_reset_frz", {24'd0, ov}, {24'd0, V_FRZ});
        do_reset();
        tick(); idle(); settle();
        chk("post_reset_run", {24'd0, ov}, {24'd0, V_RUN});

        // Redirect frozen during DMEM_WAIT, acted on at resume; small counter saturates.
        do_reset();
        tick(); hif.dmem_req = 1'b1; hif.ex_redirect = 1'b1; settle();
        chk("dw_redir_ignored", {24'd0, ov}, {24'd0, V_FRZ});
        tick(); settle();
        chk("dw_redir_wait", {24'd0, ov}, {24'd0, V_FRZ});
        tick(); hif.dmem_resp = 1'b1; settle();
        chk("dw_redir_resume", {24'd0, ov}, {24'd0, V_RDR});
        tick(); idle(); settle();
        chk("dw_flush_cnt", hif.flush_cnt, 32'd1);
        chk("dw_stall_cnt_small", {30'd0, hif_s.stall_cnt}, 32'd2);
        tick(); set_lu(5'd9, 5'd2, 5'd9); settle();
        chk("sat_lu1", {24'd0, ov}, {24'd0, V_LU});
        tick(); settle();
        tick(); settle();
        chk("sat_small_mid", {30'd0, hif_s.stall_cnt}, 32'd3);
        tick(); idle(); settle();
        chk("sat_big_cnt", hif.stall_cnt, 32'd5);
        chk("sat_small_cnt", {30'd0, hif_s.stall_cnt}, 32'd3);
        chk("sat_small_flush", {30'd0, hif_s.flush_cnt}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
